// File: rtl/ro_puf_sequencer.sv
// -----------------------------------------------------------------------------
// ro_puf_sequencer
//
// Sequences the ring-oscillator pair races that make up one PUF response.
// For every response bit the block selects a pair of oscillators derived from
// the latched challenge, holds the two edge counters cleared for CLR_CYC
// cycles, and then lets the selected oscillators run. Whichever counter pulses
// its finished line first decides the bit: counter A first gives 1, counter B
// first gives 0. Ties and timeouts resolve to 0 and raise the sticky err flag.
// Each result is shifted into the response word at index i, so bit 0 is the
// first measurement.
//
// Pair for bit i: sel_a = challenge + 2i, sel_b = challenge + 2i + 1, both
// wrapping modulo 2**SEL_W.
//
// Optional build macro: RO_PUF_TIE_RETRY_EN
//   When defined, a tie or timeout re-measures the same pair exactly once.
//   The retry result is used normally. A second tie/timeout gives bit 0 and
//   sets err. A successful retry leaves err untouched.
//   When undefined, a tie or timeout resolves at once to bit 0 with err set.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous reset, active low
//   start       in   begin a response generation (sampled only in IDLE)
//   challenge   in   base oscillator index, latched on an accepted start
//   finished_a  in   one-cycle pulse from counter A
//   finished_b  in   one-cycle pulse from counter B
//   sel_a       out  oscillator select for counter A
//   sel_b       out  oscillator select for counter B
//   ro_en       out  enables the selected oscillators
//   cnt_clr     out  holds both counters cleared while high
//   busy        out  high from accepted start until done
//   done        out  one-cycle pulse when the response is valid
//   response    out  response word, bit 0 = first measurement
//   err         out  sticky per run; set on tie or timeout
// -----------------------------------------------------------------------------
module ro_puf_sequencer #(
    parameter int SEL_W     = 4,
    parameter int RESP_BITS = 8,
    parameter int CLR_CYC   = 4,
    parameter int TIMEOUT   = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SEL_W-1:0]     challenge,
    input  logic                 finished_a,
    input  logic                 finished_b,
    output logic [SEL_W-1:0]     sel_a,
    output logic [SEL_W-1:0]     sel_b,
    output logic                 ro_en,
    output logic                 cnt_clr,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response,
    output logic                 err
);

    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        STORE,
        DONE
    } state_t;

    state_t             state_reg;
    logic [SEL_W-1:0]   chal_reg;
    logic [IDX_W-1:0]   bit_idx_reg;
    logic [CLR_W-1:0]   clr_cnt_reg;
    logic [TMR_W-1:0]   timer_reg;
    logic               bit_val_reg;
`ifdef RO_PUF_TIE_RETRY_EN
    logic               retry_used_reg;
`endif

    // Race outcome for the current RUN cycle.
    logic race_win;     // exactly one counter finished
    logic race_fail;    // tie, or last RUN cycle with no pulse at all

    always_comb begin
        race_win  = finished_a ^ finished_b;
        race_fail = (finished_a & finished_b)
                  | (~finished_a & ~finished_b & (timer_reg == TMR_LAST));
    end

    // Base oscillator of the pair for bit index idx; the offset is 2*idx and
    // the sum wraps modulo 2**SEL_W.
    function automatic logic [SEL_W-1:0] pair_base(
        input logic [SEL_W-1:0] base,
        input logic [IDX_W-1:0] idx
    );
        logic [SEL_W-1:0] offset;
        offset = SEL_W'({idx, 1'b0});
        return base + offset;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            chal_reg       <= '0;
            bit_idx_reg    <= '0;
            clr_cnt_reg    <= '0;
            timer_reg      <= '0;
            bit_val_reg    <= 1'b0;
`ifdef RO_PUF_TIE_RETRY_EN
            retry_used_reg <= 1'b0;
`endif
            sel_a          <= '0;
            sel_b          <= '0;
            ro_en          <= 1'b0;
            cnt_clr        <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            response       <= '0;
            err            <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ro_en   <= 1'b0;
                    cnt_clr <= 1'b1;
                    done    <= 1'b0;
                    if (start) begin
                        chal_reg       <= challenge;
                        bit_idx_reg    <= '0;
                        clr_cnt_reg    <= '0;
                        timer_reg      <= '0;
`ifdef RO_PUF_TIE_RETRY_EN
                        retry_used_reg <= 1'b0;
`endif
                        response       <= '0;
                        err            <= 1'b0;
                        busy           <= 1'b1;
                        // Pair for bit 0 is presented from the first CLEAR cycle.
                        sel_a          <= challenge;
                        sel_b          <= challenge + SEL_W'(1);
                        state_reg      <= CLEAR;
                    end
                end

                CLEAR: begin
                    if (clr_cnt_reg == CLR_LAST) begin
                        // Release the counters and start the race together.
                        cnt_clr   <= 1'b0;
                        ro_en     <= 1'b1;
                        timer_reg <= '0;
                        state_reg <= RUN;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + CLR_W'(1);
                    end
                end

                RUN: begin
                    timer_reg <= timer_reg + TMR_W'(1);
                    if (race_win) begin
                        ro_en       <= 1'b0;
                        cnt_clr     <= 1'b1;
                        bit_val_reg <= finished_a;
                        state_reg   <= STORE;
                    end else if (race_fail) begin
                        ro_en   <= 1'b0;
                        cnt_clr <= 1'b1;
`ifdef RO_PUF_TIE_RETRY_EN
                        if (!retry_used_reg) begin
                            // Re-measure the same pair; selects are untouched.
                            retry_used_reg <= 1'b1;
                            clr_cnt_reg    <= '0;
                            timer_reg      <= '0;
                            state_reg      <= CLEAR;
                        end else begin
                            bit_val_reg <= 1'b0;
                            err         <= 1'b1;
                            state_reg   <= STORE;
                        end
`else
                        bit_val_reg <= 1'b0;
                        err         <= 1'b1;
                        state_reg   <= STORE;
`endif
                    end
                end

                STORE: begin
                    response[bit_idx_reg] <= bit_val_reg;
                    timer_reg             <= '0;
`ifdef RO_PUF_TIE_RETRY_EN
                    retry_used_reg        <= 1'b0;
`endif
                    if (bit_idx_reg == LAST_IDX) begin
                        // done and the falling busy appear in the same cycle.
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                        clr_cnt_reg <= '0;
                        sel_a       <= pair_base(chal_reg, bit_idx_reg + IDX_W'(1));
                        sel_b       <= pair_base(chal_reg, bit_idx_reg + IDX_W'(1))
                                       + SEL_W'(1);
                        state_reg   <= CLEAR;
                    end
                end

                DONE: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                    ro_en     <= 1'b0;
                    cnt_clr   <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ro_puf_sequencer
//
// Directed bench for ro_puf_sequencer (SEL_W=4, RESP_BITS=8, CLR_CYC=4,
// TIMEOUT=100). Each bit of a response is driven with a per-bit mode:
//   0 = A wins, 1 = B wins, 2 = tie, 3 = no pulse (timeout).
// Expected selects, run lengths, latency, response and err are computed here.
// -----------------------------------------------------------------------------
module tb_ro_puf_sequencer;

    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] challenge;
    logic       finished_a;
    logic       finished_b;
    logic [3:0] sel_a;
    logic [3:0] sel_b;
    logic       ro_en;
    logic       cnt_clr;
    logic       busy;
    logic       done;
    logic [7:0] response;
    logic       err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int overlap_cnt = 0;

    ro_puf_sequencer #(
        .SEL_W     (4),
        .RESP_BITS (8),
        .CLR_CYC   (4),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .challenge  (challenge),
        .finished_a (finished_a),
        .finished_b (finished_b),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .ro_en      (ro_en),
        .cnt_clr    (cnt_clr),
        .busy       (busy),
        .done       (done),
        .response   (response),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Cycle count and ro_en/cnt_clr overlap count, sampled at the active edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ro_en && cnt_clr) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sel_a"},    32'(sel_a),    32'h0);
        check({tag, "_sel_b"},    32'(sel_b),    32'h0);
        check({tag, "_ro_en"},    32'(ro_en),    32'h0);
        check({tag, "_cnt_clr"},  32'(cnt_clr),  32'h1);
        check({tag, "_busy"},     32'(busy),     32'h0);
        check({tag, "_done"},     32'(done),     32'h0);
        check({tag, "_response"}, 32'(response), 32'h0);
        check({tag, "_err"},      32'(err),      32'h0);
    endtask

    // One measurement: wait for RUN, check the pair, drive pulses per mode,
    // then check the RUN length and that the pair holds into the next cycle.
    // Called and returns on a negedge.
    task automatic do_bit(input string name, input int i, input logic [3:0] chal,
                          input int mode, input int d, input int exp_gap);
        logic [3:0] ea;
        logic [3:0] eb;
        int n;
        int run;
        int exp_run;
        ea = chal + 4'(2 * i);
        eb = ea + 4'd1;
        exp_run = (mode == 3) ? TMO : d + 1;
        n = 0;
        finished_b = 1'b0;
        while (ro_en !== 1'b1 && n < 300) begin
            // stray pulse outside RUN must be ignored
            finished_a = (mode == 1);
            @(negedge clk);
            n++;
        end
        finished_a = 1'b0;
        check($sformatf("%s_b%0d_gap", name, i), 32'(n), 32'(exp_gap));
        check($sformatf("%s_b%0d_sel_a", name, i), 32'(sel_a), 32'(ea));
        check($sformatf("%s_b%0d_sel_b", name, i), 32'(sel_b), 32'(eb));
        check($sformatf("%s_b%0d_clr_run", name, i), 32'(cnt_clr), 32'h0);
        run = 0;
        while (ro_en === 1'b1 && run < 300) begin
            finished_a = (run == d) && (mode == 0 || mode == 2);
            finished_b = (run == d) && (mode == 1 || mode == 2);
            @(negedge clk);
            run++;
        end
        check($sformatf("%s_b%0d_run_len", name, i), 32'(run), 32'(exp_run));
        check($sformatf("%s_b%0d_sel_hold", name, i), 32'({sel_a, sel_b}), 32'({ea, eb}));
        check($sformatf("%s_b%0d_clr_after", name, i), 32'(cnt_clr), 32'h1);
        // slower counter finishes after the race is over
        finished_a = (mode == 1);
        finished_b = (mode == 0);
    endtask

    task automatic run_resp(input string name, input logic [3:0] chal, input logic [15:0] modes,
                            input logic hold_start, input logic [7:0] exp_resp, input logic exp_err);
        int t0;
        int exp_lat;
        int m;
        int d;
        int n;
        int ov0;
        ov0 = overlap_cnt;
        challenge = chal;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        if (hold_start) challenge = ~chal;
        else start = 1'b0;
        check({name, "_busy_start"}, 32'(busy), 32'h1);
        exp_lat = 1;
        for (int i = 0; i < 8; i++) begin
            m = int'(modes[2*i +: 2]);
            d = i % 3;
            do_bit(name, i, chal, m, d, (i == 0) ? 4 : 5);
            exp_lat += 4 + ((m == 3) ? TMO : d + 1) + 1;
`ifdef RO_PUF_TIE_RETRY_EN
            if (m >= 2) begin
                do_bit({name, "_retry"}, i, chal, (m == 2) ? 0 : 3, d, 4);
                exp_lat += 4 + ((m == 3) ? TMO : d + 1);
            end
`endif
        end
        start = 1'b0;
        finished_a = 1'b0;
        finished_b = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"},     32'(done),     32'h1);
        check({name, "_latency"},  32'(cyc - t0), 32'(exp_lat));
        check({name, "_busy_end"}, 32'(busy),     32'h0);
        check({name, "_response"}, 32'(response), 32'(exp_resp));
        check({name, "_err"},      32'(err),      32'(exp_err));
        check({name, "_overlap"},  32'(overlap_cnt - ov0), 32'h0);
        @(negedge clk);
        check({name, "_done_once"},     32'(done),     32'h0);
        check({name, "_busy_idle"},     32'(busy),     32'h0);
        check({name, "_response_hold"}, 32'(response), 32'(exp_resp));
        check({name, "_err_hold"},      32'(err),      32'(exp_err));
    endtask

    initial begin
        int n;
        rst = 1'b0;
        start = 1'b0;
        challenge = 4'h0;
        finished_a = 1'b0;
        finished_b = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("in_reset");
        rst = 1'b1;
        @(negedge clk);
        check_reset("idle");

        // A wins every bit; pairs (3,4),(5,6),...,(F,0),(1,2)
        run_resp("basic", 4'h3, 16'h0000, 1'b0, 8'hFF, 1'b0);

        // tie on bit 3, A wins elsewhere
`ifdef RO_PUF_TIE_RETRY_EN
        run_resp("tie", 4'h0, 16'h0080, 1'b0, 8'hFF, 1'b0);
`else
        run_resp("tie", 4'h0, 16'h0080, 1'b0, 8'hF7, 1'b1);
`endif

        // A wins bits 0,2,5; err from the previous run must be cleared
        run_resp("mixed", 4'h5, 16'h5144, 1'b0, 8'h25, 1'b0);

        // wrap-around: (E,F),(0,1),...,(C,D); A wins even bits
        run_resp("wrap", 4'hE, 16'h4444, 1'b0, 8'h55, 1'b0);

        // no pulses at all; start held high (with another challenge) while busy
        run_resp("timeout", 4'h9, 16'hFFFF, 1'b1, 8'h00, 1'b1);

        // async reset during RUN of bit 4
        challenge = 4'h2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) do_bit("rstrun", i, 4'h2, 0, i % 3, (i == 0) ? 4 : 5);
        finished_a = 1'b0;
        finished_b = 1'b0;
        n = 0;
        while (ro_en !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("rstrun_b4_gap", 32'(n), 32'd5);
        check("rstrun_partial", 32'(response), 32'h0F);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("post_reset");

        run_resp("after_rst", 4'h7, 16'h5144, 1'b0, 8'h25, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
